// File: rtl/serial_pkg.sv
// Shared types and defaults for the parallel-in, serial-out transmitter.
package serial_pkg;

  localparam int unsigned WIDTH_DEF     = 8;
  localparam int unsigned DIV_WIDTH_DEF = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } serial_state_t;

endpackage

// File: rtl/serial_tx_if.sv
// Word handshake plus serial-line signals of the transmitter.
interface serial_tx_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_WIDTH = 8
);

  logic [WIDTH-1:0]     data;
  logic                 valid;
  logic                 ready;
  logic                 left;
  logic [DIV_WIDTH-1:0] div;
  logic                 s_out;
  logic                 s_en;
  logic                 busy;
  logic                 done;

  // Word source / line observer side.
  modport master (
    output data, valid, left, div,
    input  ready, s_out, s_en, busy, done
  );

  // Transmitter side.
  modport slave (
    input  data, valid, left, div,
    output ready, s_out, s_en, busy, done
  );

endinterface

// File: rtl/m_counter.sv
// Loadable up/down counter with synchronous clear.
module m_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic         up,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load, load wins over count.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= up ? q + W'(1) : q - W'(1);
    end
  end

endmodule

// File: rtl/m_serial_tx.sv
// Serializes a WIDTH-bit word onto s_out, one bit per (div+1) clocks.
module m_serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        clr,
  serial_tx_if.slave  bus
);

  localparam int unsigned BW = $clog2(WIDTH);

  serial_state_t        state;
  logic [WIDTH-1:0]     shreg;
  logic                 left_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 done_q;

  logic [DIV_WIDTH-1:0] per_q;
  logic [DIV_WIDTH-1:0] per_d;
  logic [BW-1:0]        bit_q;
  logic                 accept;
  logic                 shifting;
  logic                 s_en_c;
  logic                 per_load;

  assign shifting = (state == S_SHIFT);
  assign accept   = bus.valid && (state == S_IDLE);
  assign s_en_c   = shifting && (per_q == '0);
  assign per_load = accept || s_en_c;
  // The first period comes straight from the port; later ones from the latched copy.
  assign per_d    = accept ? bus.div : div_q;

  m_counter #(.W(DIV_WIDTH)) u_period (
    .clk  (clk),
    .clr  (clr),
    .en   (shifting),
    .load (per_load),
    .up   (1'b0),
    .d    (per_d),
    .q    (per_q)
  );

  m_counter #(.W(BW)) u_bits (
    .clk  (clk),
    .clr  (clr),
    .en   (s_en_c),
    .load (accept),
    .up   (1'b0),
    .d    (BW'(WIDTH - 1)),
    .q    (bit_q)
  );

  // State, shift register, latched parameters and the done pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= S_IDLE;
      shreg  <= '0;
      left_q <= 1'b0;
      div_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.valid) begin
          shreg  <= bus.data;
          left_q <= bus.left;
          div_q  <= bus.div;
          state  <= S_SHIFT;
        end
      end else if (s_en_c) begin
        // Shift toward the output end with zero fill.
        if (left_q) begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        end else begin
          shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
        if (bit_q == '0) begin
          state  <= S_IDLE;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.busy  = shifting;
  assign bus.s_out = shifting && (left_q ? shreg[WIDTH-1] : shreg[0]);
  assign bus.s_en  = s_en_c;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_m_serial_tx.sv
// Scoreboard bench for m_serial_tx: stimulus queues expected words, a monitor checks the line.
module tb_m_serial_tx;

  localparam int unsigned W  = 8;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  serial_tx_if #(.WIDTH(W), .DIV_WIDTH(DW)) bus ();

  m_serial_tx #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    bit           left;
    int           div;
    int           acc;
    bit           chain;
  } word_t;

  word_t exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit end_req = 1'b0;
  bit end_ack = 1'b0;
  bit stim_timeout = 1'b0;
  bit hold_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_bit(input logic [W-1:0] d, input bit l, input int k);
    return l ? d[int'(W) - 1 - k] : d[k];
  endfunction

  // Monitor: bit k of a word occupies cycles k*(div+1)..k*(div+1)+div after its accept edge.
  initial begin : monitor
    word_t        cur;
    bit           have;
    bit           rst_prev;
    logic [W-1:0] rx;
    int           last_done;
    int           n, per, total, k;
    have      = 1'b0;
    rst_prev  = 1'b0;
    rx        = '0;
    last_done = -100;
    forever begin
      @(negedge clk);
      if (end_req) begin
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("word_in_flight", 32'(have), 32'd0);
        chk("stim_timeout", 32'(stim_timeout), 32'd0);
        end_ack = 1'b1;
        break;
      end
      if (rst_prev) begin
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_s_out", 32'(bus.s_out), 32'd0);
        chk("rst_s_en", 32'(bus.s_en), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        have = 1'b0;
      end else begin
        if (!have && bus.busy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_busy", 32'(bus.busy), 32'd0);
          end else begin
            cur  = exp_q.pop_front();
            have = 1'b1;
            rx   = '0;
            chk("start_cycle", 32'(cyc - cur.acc), 32'd0);
            if (cur.chain) chk("chain_gap", 32'(cur.acc - last_done), 32'd1);
          end
        end
        if (have) begin
          per   = cur.div + 1;
          total = int'(W) * per;
          n     = cyc - cur.acc;
          if (n < total) begin
            k = n / per;
            chk("busy", 32'(bus.busy), 32'd1);
            chk("ready_low", 32'(bus.ready), 32'd0);
            chk("s_out", 32'(bus.s_out), 32'(exp_bit(cur.data, cur.left, k)));
            chk("s_en", 32'(bus.s_en), 32'((n % per) == cur.div));
            chk("done_low", 32'(bus.done), 32'd0);
            if (bus.s_en) rx = cur.left ? {rx[W-2:0], bus.s_out} : {bus.s_out, rx[W-1:1]};
          end else begin
            chk("done", 32'(bus.done), 32'd1);
            chk("ready_at_done", 32'(bus.ready), 32'd1);
            chk("busy_at_done", 32'(bus.busy), 32'd0);
            chk("rx_word", 32'(rx), 32'(cur.data));
            last_done = cyc;
            have      = 1'b0;
          end
        end else if (!bus.busy) begin
          chk("idle_done", 32'(bus.done), 32'd0);
          chk("idle_s_en", 32'(bus.s_en), 32'd0);
          chk("idle_s_out", 32'(bus.s_out), 32'd0);
          chk("idle_ready", 32'(bus.ready), 32'd1);
        end
      end
      rst_prev = clr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word until accepted; the expected word is queued with its accept cycle.
  task automatic send(input logic [W-1:0] d, input bit l, input int dv, input bit keep,
                      output int acc);
    bit rd;
    int t;
    bit chain;
    t     = 0;
    chain = hold_valid;
    acc   = -1;
    bus.data  = d;
    bus.left  = l;
    bus.div   = DW'(dv);
    bus.valid = 1'b1;
    while (acc < 0) begin
      @(negedge clk);
      rd = bus.ready;
      tick();
      if (rd) begin
        acc = cyc;
      end else begin
        t++;
        if (t > 2000) begin
          stim_timeout = 1'b1;
          break;
        end
      end
    end
    if (acc >= 0) exp_q.push_back('{d, l, dv, acc, chain});
    hold_valid = keep && (acc >= 0);
    if (!hold_valid) bus.valid = 1'b0;
  endtask

  // Scramble the sampled inputs and pulse valid while a word is in flight.
  task automatic disturb();
    repeat (2) begin
      tick();
      bus.data  = W'($urandom);
      bus.left  = 1'($urandom);
      bus.div   = DW'($urandom);
      bus.valid = 1'b1;
      tick();
      bus.valid = 1'b0;
    end
  endtask

  initial begin : stimulus
    int           a;
    logic [W-1:0] d;
    bit           l;
    bit           keep;
    int           dv;
    bus.data  = '0;
    bus.left  = 1'b0;
    bus.div   = '0;
    bus.valid = 1'b0;
    repeat (3) tick();
    clr = 1'b0;
    repeat (2) tick();

    send(8'hA5, 1'b1, 3, 1'b0, a);
    send(8'h01, 1'b0, 1, 1'b0, a);
    send(8'hFF, 1'b1, 0, 1'b1, a);
    send(8'h3C, 1'b1, 0, 1'b0, a);

    // Abort a word partway through.
    send(8'hC3, 1'b1, 3, 1'b0, a);
    while (a >= 0 && cyc < a + 10) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    send(8'h5A, 1'b0, 3, 1'b0, a);

    send(8'h96, 1'b1, 2, 1'b0, a);
    disturb();
    send(8'h3B, 1'b0, 0, 1'b0, a);
    disturb();

    for (int i = 0; i < 24; i++) begin
      d    = W'($urandom);
      l    = 1'($urandom);
      dv   = int'($urandom_range(0, 4));
      keep = ($urandom_range(0, 3) == 0);
      send(d, l, dv, keep, a);
      if (!keep) begin
        if ($urandom_range(0, 1) == 1) disturb();
        repeat ($urandom_range(0, 12)) tick();
      end
    end
    bus.valid  = 1'b0;
    hold_valid = 1'b0;

    repeat (100) tick();
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(posedge clk);
    if (!end_ack) $display("FAIL monitor_end: got no final report expected one");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
